// File: rtl/wdm_pkg.sv
// Shared types and helpers for the WDM photonic read-out chain.
// Holds the photodetector quantizer model and the averaging-stage state encoding.
package wdm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        HOLD = 2'd2
    } pd_avg_state_e;

    localparam int unsigned PdMaxAvgLog2 = 32'd8;

    // floor(current / full_scale * 2^width), clipped to [0, 2^width-1]; NaN fails the >= test and clips low
    function automatic int pd_quantize(
        input  real  current,
        input  real  full_scale,
        input  int   width,
        output logic sat
    );
        real scaled;
        real top;
        int  code;
        scaled = current / full_scale * $itor(32'sd1 <<< width);
        top    = $itor(32'sd1 <<< width);
        if (!(scaled >= 0.0)) begin
            code = 32'sd0;
            sat  = 1'b1;
        end else if (scaled >= top) begin
            code = (32'sd1 <<< width) - 32'sd1;
            sat  = 1'b1;
        end else begin
            code = $rtoi(scaled);
            sat  = 1'b0;
        end
        return code;
    endfunction

endpackage

// File: rtl/pd_sample_avg_quantizer.sv
// Combinational quantizer: photodetector current to unsigned code plus clip flag.
module pd_quantizer
    import wdm_pkg::*;
#(
    parameter int  CodeWidth = 10,
    parameter real FullScale = 1.0e-3
) (
    input  real                  i_real_current,
    output logic [CodeWidth-1:0] o_code,
    output logic                 o_sat
);

    // Quantize the instantaneous current.
    always_comb begin
        o_sat  = 1'b0;
        o_code = CodeWidth'(pd_quantize(i_real_current, FullScale, CodeWidth, o_sat));
    end

endmodule

// File: rtl/pd_sample_avg.sv
// Photodetector read-out: averages 2^AvgLog2 quantized samples per measurement,
// tracks peak and saturation, and hands the result out over valid/ready.
module pd_sample_avg
    import wdm_pkg::*;
#(
    parameter int  CodeWidth = 10,
    parameter real FullScale = 1.0e-3,
    parameter int  AvgLog2   = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  real                  i_real_current,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [CodeWidth-1:0] o_avg,
    output logic [CodeWidth-1:0] o_peak,
    output logic                 o_sat
);

    localparam int AccWidth = CodeWidth + AvgLog2;
    localparam int CntWidth = (AvgLog2 > 0) ? AvgLog2 : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'((32'd1 << AvgLog2) - 32'd1);

    typedef struct packed {
        logic [CodeWidth-1:0] avg;
        logic [CodeWidth-1:0] peak;
        logic                 sat;
    } pd_meas_t;

    pd_avg_state_e         state_q, state_d;
    logic [AccWidth-1:0]   acc_q, acc_d, sum_s;
    logic [CodeWidth-1:0]  peak_q, peak_d, peak_nxt_s, code_s;
    logic                  sat_q, sat_d, sat_nxt_s, sat_sample_s;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    pd_meas_t              meas_q, meas_d;
    logic                  busy_q, busy_d, valid_q, valid_d;
    logic                  handshake_s, start_acq_s;

    pd_quantizer #(
        .CodeWidth (CodeWidth),
        .FullScale (FullScale)
    ) u_quantizer (
        .i_real_current (i_real_current),
        .o_code         (code_s),
        .o_sat          (sat_sample_s)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; starts are honoured only from IDLE or on a completed handshake.
    always_comb begin
        handshake_s = valid_q & i_ready;
        state_d     = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) state_d = ACQ;
                else         state_d = IDLE;
            end
            ACQ: begin
                if (cnt_q == CntLast) state_d = HOLD;
                else                  state_d = ACQ;
            end
            HOLD: begin
                if (handshake_s) state_d = i_start ? ACQ : IDLE;
                else             state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase
        start_acq_s = (state_d == ACQ) && (state_q != ACQ);
    end

    // Status outputs derived from the upcoming state so they register cleanly.
    always_comb begin
        busy_d  = (state_d == ACQ);
        valid_d = (state_d == HOLD);
    end

    // Accumulate, peak and saturation tracking; result loads on the last sample edge.
    always_comb begin
        sum_s      = acc_q + AccWidth'(code_s);
        peak_nxt_s = (code_s > peak_q) ? code_s : peak_q;
        sat_nxt_s  = sat_q | sat_sample_s;
        acc_d      = acc_q;
        peak_d     = peak_q;
        sat_d      = sat_q;
        cnt_d      = cnt_q;
        meas_d     = meas_q;
        if (state_q == ACQ) begin
            acc_d  = sum_s;
            peak_d = peak_nxt_s;
            sat_d  = sat_nxt_s;
            cnt_d  = cnt_q + CntWidth'(32'd1);
            if (cnt_q == CntLast) begin
                meas_d = '{avg: sum_s[AccWidth-1:AvgLog2], peak: peak_nxt_s, sat: sat_nxt_s};
            end else begin
                meas_d = meas_q;
            end
        end else if (start_acq_s) begin
            acc_d  = {AccWidth{1'b0}};
            peak_d = {CodeWidth{1'b0}};
            sat_d  = 1'b0;
            cnt_d  = {CntWidth{1'b0}};
        end else begin
            acc_d  = acc_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc_q   <= {AccWidth{1'b0}};
            peak_q  <= {CodeWidth{1'b0}};
            sat_q   <= 1'b0;
            cnt_q   <= {CntWidth{1'b0}};
            meas_q  <= {(2 * CodeWidth + 1){1'b0}};
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            peak_q  <= peak_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            meas_q  <= meas_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o_avg   = meas_q.avg;
    assign o_peak  = meas_q.peak;
    assign o_sat   = meas_q.sat;

endmodule

// File: tb/tb_pd_sample_avg.sv
// Directed bench for pd_sample_avg with a result scoreboard (defaults: 10-bit code, 1 mA, N=8).
module tb_pd_sample_avg;

    typedef struct {
        int avg;
        int peak;
        int sat;
    } exp_t;

    logic       clk;
    logic       rst_n;
    real        cur;
    logic       start;
    logic       ready;
    logic       busy;
    logic       valid;
    logic [9:0] avg;
    logic [9:0] peak;
    logic       sat;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   bc;
    real  cur_tab [8];
    exp_t sb [$];

    pd_sample_avg dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_real_current (cur),
        .i_start        (start),
        .o_busy         (busy),
        .o_valid        (valid),
        .i_ready        (ready),
        .o_avg          (avg),
        .o_peak         (peak),
        .o_sat          (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_const(input real v);
        for (int i = 0; i < 8; i++) cur_tab[i] = v;
    endtask

    task automatic start_meas();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feed samples from cur_tab until o_valid, counting busy cycles; bounded.
    task automatic acquire(output int busy_cycles);
        int k;
        k = 0;
        busy_cycles = 0;
        while (!valid && k < 40) begin
            cur = cur_tab[k % 8];
            if (busy) busy_cycles++;
            tick();
            k++;
        end
        check("valid_timeout", int'(valid), 1);
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_avg"},  int'(avg),  e.avg);
            check({tag, "_peak"}, int'(peak), e.peak);
            check({tag, "_sat"},  int'(sat),  e.sat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        cur   = 0.0;
        tick();
        tick();
        check("rst_busy",  int'(busy),  0);
        check("rst_valid", int'(valid), 0);
        check("rst_avg",   int'(avg),   0);
        check("rst_peak",  int'(peak),  0);
        check("rst_sat",   int'(sat),   0);
        rst_n = 1'b1;
        tick();

        // Constant half-scale with an immediate consumer.
        ready = 1'b1;
        set_const(0.5e-3);
        sb.push_back('{512, 512, 0});
        start_meas();
        acquire(bc);
        check("const_busy_cycles", bc, 8);
        compare_result("const");
        tick();
        check("const_idle_valid", int'(valid), 0);
        check("const_hold_avg",   int'(avg),   512);

        // Ramp.
        cur_tab = '{0.0, 0.1e-3, 0.2e-3, 0.3e-3, 0.4e-3, 0.5e-3, 0.6e-3, 0.7e-3};
        sb.push_back('{358, 716, 0});
        start_meas();
        acquire(bc);
        compare_result("ramp");
        tick();

        // Alternating over- and under-range.
        cur_tab = '{2.0e-3, -0.1e-3, 2.0e-3, -0.1e-3, 2.0e-3, -0.1e-3, 2.0e-3, -0.1e-3};
        sb.push_back('{511, 1023, 1});
        start_meas();
        acquire(bc);
        compare_result("alt");
        tick();

        // Backpressure with ignored starts, then a back-to-back start on the handshake edge.
        ready = 1'b0;
        set_const(0.25e-3);
        sb.push_back('{256, 256, 0});
        start_meas();
        acquire(bc);
        compare_result("bp");
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0) ? 1'b1 : 1'b0;
            cur   = 0.9e-3;
            tick();
            check("bp_valid", int'(valid), 1);
            check("bp_busy",  int'(busy),  0);
            check("bp_avg",   int'(avg),   256);
        end
        ready = 1'b1;
        set_const(0.75e-3);
        sb.push_back('{768, 768, 0});
        start_meas();
        check("b2b_busy",     int'(busy),  1);
        check("b2b_valid",    int'(valid), 0);
        check("b2b_hold_avg", int'(avg),   256);
        acquire(bc);
        check("b2b_busy_cycles", bc, 8);
        compare_result("b2b");
        tick();

        // Reset on the 4th sample edge aborts the measurement.
        set_const(0.9e-3);
        cur = 0.9e-3;
        start_meas();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mrst_busy",  int'(busy),  0);
        check("mrst_valid", int'(valid), 0);
        check("mrst_avg",   int'(avg),   0);
        check("mrst_peak",  int'(peak),  0);
        check("mrst_sat",   int'(sat),   0);
        rst_n = 1'b1;
        tick();
        check("mrst_idle_busy", int'(busy), 0);
        set_const(0.1e-3);
        sb.push_back('{102, 102, 0});
        start_meas();
        acquire(bc);
        compare_result("post_rst");
        tick();

        // Top-of-range boundary: just below full scale, then exactly full scale.
        set_const(0.999e-3);
        sb.push_back('{1022, 1022, 0});
        start_meas();
        acquire(bc);
        compare_result("below_fs");
        tick();
        set_const(1.0e-3);
        sb.push_back('{1023, 1023, 1});
        start_meas();
        acquire(bc);
        compare_result("at_fs");
        tick();

        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
